// File: rtl/sample_packer_pkg.sv
// sample_packer_pkg: shared mode codes, FSM state and sample-width helper
// used by sample_packer and bit_accumulator.
package sample_packer_pkg;

  localparam logic [1:0] MODE_QUANT = 2'd0;
  localparam logic [1:0] MODE_RAW_I = 2'd1;
  localparam logic [1:0] MODE_RAW_Q = 2'd2;
  localparam logic [1:0] MODE_TEST  = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Bits contributed per strobed sample in a given mode.
  // Test mode bypasses the accumulator, so it appends nothing.
  function automatic int sb_of(
    input logic [1:0] m,
    input int         sb_q,
    input int         raw_w
  );
    int r;
    case (m)
      MODE_QUANT: r = sb_q;
      MODE_RAW_I: r = raw_w;
      MODE_RAW_Q: r = raw_w;
      default:    r = 0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sample_packer_bit_accumulator.sv
// bit_accumulator: MSB-first variable-width bit packer.
// Ports: clk, rst_n (sync, active-low); in_valid/in_data/in_bits
// append a right-aligned sample of in_bits bits; flush drops any
// remainder after this cycle's extraction; word_valid/word give the
// top WORD_W bits whenever the fill reaches WORD_W; fill is the count
// of held bits.
module bit_accumulator
  import sample_packer_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int SB_MAX = 12,
  localparam int ACC_W = WORD_W + SB_MAX - 1,
  localparam int CW    = $clog2(WORD_W + SB_MAX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [SB_MAX-1:0] in_data,
  input  logic [CW-1:0]     in_bits,
  input  logic              flush,
  output logic              word_valid,
  output logic [WORD_W-1:0] word,
  output logic [CW-1:0]     fill
);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CW-1:0]     fill_q, fill_d;
  logic [SB_MAX-1:0] s_top;
  logic [ACC_W-1:0]  s_ext;
  logic [ACC_W-1:0]  merged;
  logic [CW-1:0]     total;

  // Held bits are left-aligned in acc_q with zeros below, so a new
  // sample is left-aligned, shifted down by the fill and OR-ed in.
  always_comb begin
    s_top      = in_data << (CW'(SB_MAX) - in_bits);
    s_ext      = {s_top, {(WORD_W-1){1'b0}}};
    merged     = acc_q | (s_ext >> fill_q);
    total      = fill_q + in_bits;
    word       = merged[ACC_W-1 -: WORD_W];
    word_valid = 1'b0;
    acc_d      = acc_q;
    fill_d     = fill_q;
    if (in_valid) begin
      acc_d  = merged;
      fill_d = total;
      if (total >= CW'(WORD_W)) begin
        word_valid = 1'b1;
        acc_d      = merged << WORD_W;
        fill_d     = total - CW'(WORD_W);
      end
    end
    if (flush) begin
      acc_d  = '0;
      fill_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

  assign fill = fill_q;

endmodule

// File: rtl/sample_packer.sv
// sample_packer: packs strobed quantized I/Q (all channels) or raw I/Q
// (one channel) MSB-first into WORD_W words framed into packets of
// PKT_WORDS words; mode/enable/raw_sel take effect at packet ends.
// Ports: source_clk, source_reset_n (sync, active-low); enable, mode,
// raw_sel control; in_valid, qi, qq, raw_i, raw_q sample inputs;
// out_data, out_en, out_packet_end, packet_count outputs.
// Macro SAMPLE_PACKER_TESTPAT_EN: mode 3 emits a per-packet word ramp;
// without it mode 3 emits nothing and re-latches mode every idle cycle.
module sample_packer
  import sample_packer_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int QBITS     = 2,
  parameter int RAW_W     = 8,
  parameter int WORD_W    = 16,
  parameter int PKT_WORDS = 720,
  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    source_clk,
  input  logic                    source_reset_n,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic [SW-1:0]           raw_sel,
  input  logic                    in_valid,
  input  logic [NUM_CH*QBITS-1:0] qi,
  input  logic [NUM_CH*QBITS-1:0] qq,
  input  logic [NUM_CH*RAW_W-1:0] raw_i,
  input  logic [NUM_CH*RAW_W-1:0] raw_q,
  output logic [WORD_W-1:0]       out_data,
  output logic                    out_en,
  output logic                    out_packet_end,
  output logic [15:0]             packet_count
);

  localparam int SB_Q   = 2 * NUM_CH * QBITS;
  localparam int SB_MAX = (SB_Q > RAW_W) ? SB_Q : RAW_W;
  localparam int CW     = $clog2(WORD_W + SB_MAX);
  localparam int WCW    = $clog2(PKT_WORDS);
  localparam logic [WCW-1:0] LAST_W = WCW'(PKT_WORDS - 1);

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic [15:0]       pkt_q, pkt_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_en_q, out_en_d;
  logic              out_end_q, out_end_d;

  logic              run;
  logic [SB_Q-1:0]   s_quant;
  logic [RAW_W-1:0]  s_raw;
  logic [SB_MAX-1:0] s_data;
  logic [CW-1:0]     s_bits;
  logic              acc_valid;
  logic              acc_flush;
  logic              acc_word_valid;
  logic [WORD_W-1:0] acc_word;
  logic [CW-1:0]     acc_fill;
  logic              tp_emit;
  logic [WORD_W-1:0] tp_word;
  logic              relatch;
  logic              emit;
  logic              last;
  logic              boundary;
  logic [WORD_W-1:0] emit_word;

  assign run = (state_q == ST_RUN);

  // Sample formation: channel 0 most significant, I before Q.
  always_comb begin
    s_quant = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      s_quant[SB_Q-1-2*k*QBITS -: QBITS] =
        qi[k*QBITS +: QBITS];
      s_quant[SB_Q-1-(2*k+1)*QBITS -: QBITS] =
        qq[k*QBITS +: QBITS];
    end
  end

  // Channel 0 is the fallback for out-of-range selects.
  always_comb begin
    s_raw = (mode_q == MODE_RAW_Q) ?
      raw_q[RAW_W-1:0] : raw_i[RAW_W-1:0];
    for (int k = 1; k < NUM_CH; k++) begin
      if (int'(sel_q) == k) begin
        s_raw = (mode_q == MODE_RAW_Q) ?
          raw_q[k*RAW_W +: RAW_W] :
          raw_i[k*RAW_W +: RAW_W];
      end
    end
  end

  always_comb begin
    unique case (mode_q)
      MODE_QUANT: s_data = SB_MAX'(s_quant);
      MODE_RAW_I: s_data = SB_MAX'(s_raw);
      MODE_RAW_Q: s_data = SB_MAX'(s_raw);
      default:    s_data = '0;
    endcase
    s_bits = CW'(sb_of(mode_q, SB_Q, RAW_W));
  end

  assign acc_valid = run && in_valid &&
                     (mode_q != MODE_TEST);

  bit_accumulator #(
    .WORD_W (WORD_W),
    .SB_MAX (SB_MAX)
  ) u_acc (
    .clk        (source_clk),
    .rst_n      (source_reset_n),
    .in_valid   (acc_valid),
    .in_data    (s_data),
    .in_bits    (s_bits),
    .flush      (acc_flush),
    .word_valid (acc_word_valid),
    .word       (acc_word),
    .fill       (acc_fill)
  );

`ifdef SAMPLE_PACKER_TESTPAT_EN
  // The ramp restarts with the word counter at each packet start.
  assign tp_emit = run && in_valid &&
                   (mode_q == MODE_TEST);
  assign tp_word = WORD_W'(wcnt_q);
  assign relatch = 1'b0;
`else
  // Mode 3 never emits, so it would never reach a packet end;
  // treat every empty packet-start cycle as a boundary instead.
  assign tp_emit = 1'b0;
  assign tp_word = '0;
  assign relatch = run && (mode_q == MODE_TEST) &&
                   (wcnt_q == '0) && (acc_fill == '0);
`endif

  assign emit      = acc_word_valid | tp_emit;
  assign emit_word = tp_emit ? tp_word : acc_word;
  assign last      = emit && (wcnt_q == LAST_W);
  assign boundary  = last | relatch;

  // FSM: state register.
  always_ff @(posedge source_clk) begin
    if (!source_reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_QUANT;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
    end
  end

  // FSM: next state and control latching.
  // Residual bits survive a boundary only if the mode is unchanged.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    sel_d     = sel_q;
    acc_flush = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
          mode_d  = mode;
          sel_d   = raw_sel;
        end
      end
      ST_RUN: begin
        if (boundary) begin
          if (!enable) begin
            state_d   = ST_IDLE;
            acc_flush = 1'b1;
          end else begin
            mode_d    = mode;
            sel_d     = raw_sel;
            acc_flush = (mode != mode_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs and counters.
  always_comb begin
    out_en_d   = emit;
    out_end_d  = last;
    out_data_d = emit ? emit_word : out_data_q;
    wcnt_d     = wcnt_q;
    pkt_d      = pkt_q;
    if (emit) begin
      wcnt_d = last ? '0 : wcnt_q + WCW'(1);
    end
    if (last) begin
      pkt_d = pkt_q + 16'd1;
    end
  end

  always_ff @(posedge source_clk) begin
    if (!source_reset_n) begin
      out_data_q <= '0;
      out_en_q   <= 1'b0;
      out_end_q  <= 1'b0;
      wcnt_q     <= '0;
      pkt_q      <= '0;
    end else begin
      out_data_q <= out_data_d;
      out_en_q   <= out_en_d;
      out_end_q  <= out_end_d;
      wcnt_q     <= wcnt_d;
      pkt_q      <= pkt_d;
    end
  end

  assign out_data       = out_data_q;
  assign out_en         = out_en_q;
  assign out_packet_end = out_end_q;
  assign packet_count   = pkt_q;

endmodule

// File: tb/tb_sample_packer.sv
// tb_sample_packer: directed stimulus with a bit-queue reference and
// a scoreboard monitor for sample_packer (default parameters).
module tb_sample_packer;

  localparam int N  = 3;
  localparam int PW = 720;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [1:0]  mode;
  logic [1:0]  raw_sel;
  logic        in_valid;
  logic [5:0]  qi, qq;
  logic [23:0] raw_i, raw_q;
  logic [15:0] out_data;
  logic        out_en;
  logic        out_packet_end;
  logic [15:0] packet_count;

  sample_packer dut (
    .source_clk     (clk),
    .source_reset_n (rst_n),
    .enable         (enable),
    .mode           (mode),
    .raw_sel        (raw_sel),
    .in_valid       (in_valid),
    .qi             (qi),
    .qq             (qq),
    .raw_i          (raw_i),
    .raw_q          (raw_q),
    .out_data       (out_data),
    .out_en         (out_en),
    .out_packet_end (out_packet_end),
    .packet_count   (packet_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic [15:0] pkt;
    int          at;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [15:0] seen[$];
  bit          seen_end[$];
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Monitor: pops one expectation per presented word.
  always @(negedge clk) begin
    if (out_en) begin
      seen.push_back(out_data);
      seen_end.push_back(out_packet_end);
      if (sbq.size() == 0) begin
        check("unexpected_word", {16'h0, out_data}, 32'hFFFF_FFFF);
      end else begin
        mon_e = sbq.pop_front();
        check("word_data", {16'h0, out_data}, {16'h0, mon_e.data});
        check("word_end", {31'h0, out_packet_end}, {31'h0, mon_e.last});
        check("word_cycle", cyc, mon_e.at);
        if (mon_e.last)
          check("pkt_count_at_end", {16'h0, packet_count},
                {16'h0, mon_e.pkt});
      end
    end else begin
      if (out_packet_end)
        check("end_without_en", 32'd1, 32'd0);
      if (sbq.size() > 0 && sbq[0].at <= cyc) begin
        mon_e = sbq.pop_front();
        check("missing_word", 32'd0, {16'h0, mon_e.data});
      end
    end
  end

  // Reference model state.
  bit          bq[$];
  bit          m_run = 0;
  logic [1:0]  m_mode = 0;
  logic [1:0]  m_sel = 0;
  int          m_wcnt = 0;
  logic [15:0] m_pkt = 0;
  int          n_exp = 0;

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int b = n - 1; b >= 0; b--) bq.push_back(v[b]);
  endtask

  task automatic boundary();
    if (!enable) begin
      m_run = 0;
      bq.delete();
    end else begin
      if (mode != m_mode) bq.delete();
      m_mode = mode;
      m_sel  = raw_sel;
    end
  endtask

  task automatic emit(input logic [15:0] w);
    exp_t e;
    e.data = w;
    e.last = (m_wcnt == PW - 1);
    e.at   = cyc + 1;
    if (e.last) begin
      m_wcnt = 0;
      m_pkt++;
    end else begin
      m_wcnt++;
    end
    e.pkt = m_pkt;
    sbq.push_back(e);
    n_exp++;
    if (e.last) boundary();
  endtask

  task automatic step();
    logic [15:0] w;
    int ch;
    if (!rst_n) begin
      m_run  = 0;
      bq.delete();
      m_wcnt = 0;
      m_pkt  = 0;
    end else if (!m_run) begin
      if (enable) begin
        m_run  = 1;
        m_mode = mode;
        m_sel  = raw_sel;
      end
    end else if (m_mode == 2'd3) begin
`ifdef SAMPLE_PACKER_TESTPAT_EN
      if (in_valid) emit(16'(m_wcnt));
`else
      if (m_wcnt == 0 && bq.size() == 0) boundary();
`endif
    end else if (in_valid) begin
      if (m_mode == 2'd0) begin
        for (int k = 0; k < N; k++) begin
          push_bits({30'h0, qi[k*2 +: 2]}, 2);
          push_bits({30'h0, qq[k*2 +: 2]}, 2);
        end
      end else begin
        ch = (int'(m_sel) < N) ? int'(m_sel) : 0;
        if (m_mode == 2'd1) push_bits({24'h0, raw_i[ch*8 +: 8]}, 8);
        else                push_bits({24'h0, raw_q[ch*8 +: 8]}, 8);
      end
      if (bq.size() >= 16) begin
        w = '0;
        for (int b = 0; b < 16; b++) w = {w[14:0], bq.pop_front()};
        emit(w);
      end
    end
  endtask

  task automatic tick();
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n);
    qi    = 6'(n * 7 + 1);
    qq    = 6'(n * 3 + 2);
    raw_i = 24'(n * 32'h0003_0507 + 32'h000A_0B0C);
    raw_q = 24'(n * 32'h0011_0713 + 32'h1);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_data"}, {16'h0, out_data}, 32'h0);
    check({nm, "_en"}, {31'h0, out_en}, 32'h0);
    check({nm, "_end"}, {31'h0, out_packet_end}, 32'h0);
    check({nm, "_pkt"}, {16'h0, packet_count}, 32'h0);
  endtask

  int n = 0;
  int base_raw;
  int tp_base;

  initial begin
    rst_n = 0; enable = 0; mode = 0; raw_sel = 0; in_valid = 0;
    qi = 0; qq = 0; raw_i = 0; raw_q = 0;
    #1;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1;

    // Constant S = 12'hABC in mode 0.
    qi = 6'h3A; qq = 6'h0E; enable = 1; mode = 0;
    tick();
    in_valid = 1;
    repeat (1000) tick();
    check("s1_w0", {16'h0, seen[0]}, 32'hABCA);
    check("s1_w1", {16'h0, seen[1]}, 32'hBCAB);
    check("s1_w2", {16'h0, seen[2]}, 32'hCABC);
    check("s1_w3", {16'h0, seen[3]}, 32'hABCA);
    check("s1_w719", {16'h0, seen[719]}, 32'hCABC);
    check("s1_end718", {31'h0, seen_end[718]}, 32'h0);
    check("s1_end719", {31'h0, seen_end[719]}, 32'h1);
    check("s1_w720", {16'h0, seen[720]}, 32'hABCA);
    check("s1_pkt", {16'h0, packet_count}, 32'h1);

    // Mode change to raw I ch2 at word 100; packet ends in mode 0.
    for (int g = 0; g < 3000 && m_pkt < 2; g++) begin
      if (m_wcnt == 100 && m_pkt == 1) begin
        mode = 1; raw_sel = 2;
      end
      drive(n++);
      tick();
    end
    // Enable drop at word 100 of the raw packet.
    for (int g = 0; g < 1000 && m_wcnt < 100; g++) begin
      drive(n++);
      tick();
    end
    enable = 0;
    for (int g = 0; g < 3000 && m_run; g++) begin
      drive(n++);
      tick();
    end
    repeat (30) begin
      drive(n++);
      tick();
    end
    check("idle_pkt", {16'h0, packet_count}, 32'h3);

    // Raw I ch0 from IDLE; the enabling cycle's sample is ignored.
    base_raw = n_exp;
    enable = 1; mode = 1; raw_sel = 0; in_valid = 1;
    raw_i = 24'h777799; tick();
    raw_i = 24'h333311; tick();
    raw_i = 24'h555522; tick();
    for (int g = 0; g < 2000 && m_wcnt < 300; g++) begin
      if (m_wcnt == 50) raw_sel = 2;
      drive(n++);
      tick();
    end
    check("raw_first", {16'h0, seen[base_raw]}, 32'h1122);

    // Reset mid-packet, then raw Q with out-of-range select.
    rst_n = 0; in_valid = 0;
    tick();
    check_zero("midreset");
    rst_n = 1; enable = 1; mode = 2; raw_sel = 3; in_valid = 1;
    repeat (200) begin
      drive(n++);
      tick();
    end

    // Test mode, then request mode 0.
    rst_n = 0; in_valid = 0;
    tick();
    rst_n = 1; enable = 1; mode = 3; in_valid = 1;
    tp_base = n_exp;
    repeat (20) begin
      drive(n++);
      tick();
    end
`ifdef SAMPLE_PACKER_TESTPAT_EN
    check("tp_w0", {16'h0, seen[tp_base]}, 32'h0);
    check("tp_w1", {16'h0, seen[tp_base + 1]}, 32'h1);
    check("tp_w2", {16'h0, seen[tp_base + 2]}, 32'h2);
`else
    check("tp_no_words", seen.size(), tp_base);
`endif
    mode = 0;
    repeat (800) begin
      drive(n++);
      tick();
    end

    in_valid = 0; enable = 0;
    repeat (5) tick();
    check("drain", sbq.size(), 0);
    check("word_total", seen.size(), n_exp);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
